change_dispenser: RTL

Returns change from the newspaper vending machine. It pays out a requested credit as a stream of coins, using the same 2-bit coin code the vend controller consumes, but in the opposite direction: machine to customer. It draws greedily from two coin tubes (10-cent and 5-cent), tracks tube inventory, and handshakes each coin with the ejector mechanism.

---
 rtl/vend_pkg.sv | 36 +++
 rtl/coin_tube.sv | 45 ++++
 rtl/change_dispenser.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: coin codes and change_dispenser state encoding.
package vend_pkg;

    localparam int unsigned COIN_W = 2;
    localparam int unsigned AMT_W  = 5;

    // Coin codes shared with vend_ctrl; the numeric value equals the value in 5-cent units.
    localparam logic [COIN_W-1:0] COIN_0  = 2'b00;
    localparam logic [COIN_W-1:0] COIN_5  = 2'b01;
    localparam logic [COIN_W-1:0] COIN_10 = 2'b10;

    typedef enum logic [1:0] {
        CD_IDLE  = 2'd0,
        CD_DISP  = 2'd1,
        CD_DONE  = 2'd2,
        CD_SHORT = 2'd3
    } cd_state_e;

    // Greedy coin choice for a given amount owed; COIN_0 means nothing can be offered.
    // A 10-cent coin is only offered when at least two units are owed, so change is never overpaid.
    function automatic logic [COIN_W-1:0] greedy_pick(
        input logic [AMT_W-1:0] rem,
        input logic             has10,
        input logic             has5
    );
        logic [COIN_W-1:0] pick;
        pick = COIN_0;
        if (rem >= AMT_W'(2) && has10) begin
            pick = COIN_10;
        end else if (rem != '0 && has5) begin
            pick = COIN_5;
        end
        return pick;
    endfunction

endpackage

// File: rtl/coin_tube.sv
// Saturating up/down inventory counter for one coin tube.
module coin_tube #(
    parameter int unsigned CW   = 6,
    parameter int unsigned INIT = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next_c
);

    localparam logic [CW-1:0] COUNT_MAX = '1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: inc and dec together cancel; inc saturates, dec stops at zero.
    always_comb begin
        count_d = count_q;
        if (inc && !dec) begin
            if (count_q != COUNT_MAX) begin
                count_d = count_q + CW'(1);
            end
        end else if (dec && !inc) begin
            if (count_q != '0) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Inventory register; refills arriving during reset are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= CW'(INIT);
        end else begin
            count_q <= count_d;
        end
    end

    assign count        = count_q;
    assign count_next_c = count_d;

endmodule

// File: rtl/change_dispenser.sv
// Change payout: streams greedy 10/5-cent coins to the ejector until the credit is paid or a tube runs dry.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned CW     = 6,
    parameter int unsigned INIT10 = 8,
    parameter int unsigned INIT5  = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [4:0]    amount,
    input  logic          coin_ready,
    input  logic          refill10,
    input  logic          refill5,
    output logic [1:0]    coin,
    output logic          coin_valid,
    output logic          busy,
    output logic          done,
    output logic          short,
    output logic [4:0]    remaining,
    output logic [CW-1:0] count10,
    output logic [CW-1:0] count5
);

    cd_state_e          state_q, state_d;
    logic [COIN_W-1:0]  coin_q, coin_d;
    logic               coin_valid_q, coin_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               short_q, short_d;
    logic [AMT_W-1:0]   rem_q, rem_d;

    logic               xfer_c;
    logic               dec10_c;
    logic               dec5_c;
    logic [CW-1:0]      c10_next_c;
    logic [CW-1:0]      c5_next_c;
    logic [AMT_W-1:0]   sel_rem_c;
    logic               sel_go_c;
    logic [COIN_W-1:0]  pick_c;

    // A coin leaves the machine when the registered offer meets ejector ready.
    assign xfer_c  = coin_valid_q && coin_ready;
    assign dec10_c = xfer_c && (coin_q == COIN_10);
    assign dec5_c  = xfer_c && (coin_q == COIN_5);

    coin_tube #(
        .CW   (CW),
        .INIT (INIT10)
    ) u_tube10 (
        .clock        (clock),
        .reset        (reset),
        .inc          (refill10),
        .dec          (dec10_c),
        .count        (count10),
        .count_next_c (c10_next_c)
    );

    coin_tube #(
        .CW   (CW),
        .INIT (INIT5)
    ) u_tube5 (
        .clock        (clock),
        .reset        (reset),
        .inc          (refill5),
        .dec          (dec5_c),
        .count        (count5),
        .count_next_c (c5_next_c)
    );

    // Next state, next offer and amount owed; selection uses post-edge inventory so refills count immediately.
    always_comb begin
        state_d      = state_q;
        coin_d       = coin_q;
        coin_valid_d = coin_valid_q;
        rem_d        = rem_q;
        sel_rem_c    = rem_q;
        sel_go_c     = 1'b0;

        case (state_q)
            CD_IDLE: begin
                if (start) begin
                    rem_d     = amount;
                    sel_rem_c = amount;
                    sel_go_c  = 1'b1;
                end
            end
            CD_DISP: begin
                if (xfer_c) begin
                    if (coin_q == COIN_10) begin
                        rem_d = rem_q - AMT_W'(2);
                    end else begin
                        rem_d = rem_q - AMT_W'(1);
                    end
                    sel_rem_c = rem_d;
                    sel_go_c  = 1'b1;
                end
            end
            default: begin
                state_d = CD_IDLE;
            end
        endcase

        pick_c = greedy_pick(sel_rem_c, (c10_next_c != '0), (c5_next_c != '0));

        if (sel_go_c) begin
            if (pick_c != COIN_0) begin
                state_d      = CD_DISP;
                coin_d       = pick_c;
                coin_valid_d = 1'b1;
            end else begin
                coin_d       = COIN_0;
                coin_valid_d = 1'b0;
                state_d      = (sel_rem_c == '0) ? CD_DONE : CD_SHORT;
            end
        end

        busy_d  = (state_d == CD_DISP);
        done_d  = (state_d == CD_DONE);
        short_d = (state_d == CD_SHORT);
    end

    // State, offer and status registers; reset abandons any payout without a done/short pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= CD_IDLE;
            coin_q       <= COIN_0;
            coin_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            short_q      <= 1'b0;
            rem_q        <= '0;
        end else begin
            state_q      <= state_d;
            coin_q       <= coin_d;
            coin_valid_q <= coin_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            short_q      <= short_d;
            rem_q        <= rem_d;
        end
    end

    assign coin       = coin_q;
    assign coin_valid = coin_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign short      = short_q;
    assign remaining  = rem_q;

endmodule
